fft_access_guard: RTL and testbench

FFT_ACCESS_GUARD -- requirements
Module: fft_access_guard

---
 rtl/fft_access_guard.sv | 163 ++++++++++++++++
 tb/tb_fft_access_guard.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_access_guard.sv
// FFT data-region access guard: tracks busy engines and stalls or
// faults loads/stores that touch a region still being computed.
module fft_access_guard #(
  parameter int          NUM_CH      = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          REGION_LOG2 = 13,
  parameter int          TIMEOUT     = 64,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startF,
  input  logic [CH_W-1:0]   startCh,
  input  logic [NUM_CH-1:0] doneVec,
  input  logic              memValid,
  input  logic              memWrite,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       pc,
  input  logic              stallMode,
  input  logic              excClr,
  output logic [NUM_CH-1:0] busyVec,
  output logic              stall,
  output logic              fftNotCompleteEx,
  output logic              exception,
  output logic [1:0]        excCause,
  output logic [CH_W-1:0]   excCh,
  output logic [31:0]       excAddr,
  output logic [31:0]       excPc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    EXC
  } state_t;

  state_t            state, stateN;
  logic [CNT_W-1:0]  cnt, cntN;
  logic [NUM_CH-1:0] busyN;
  logic [1:0]        causeN;
  logic [CH_W-1:0]   chN;
  logic [31:0]       addrN, pcN;

  logic [31:0]       offset, idxFull;
  logic [CH_W-1:0]   idx;
  logic              hit, guard, startOk, startViol, holdCh;
  logic              unusedWrite;

  assign unusedWrite = memWrite;

  always_comb begin
    offset    = memAddr - BASE_ADDR;
    idxFull   = offset >> REGION_LOG2;
    idx       = idxFull[CH_W-1:0];
    hit       = (memAddr >= BASE_ADDR) && (idxFull < 32'(NUM_CH));
    guard     = memValid & hit & busyVec[idx] & ~doneVec[idx];
    startOk   = startF & (32'(startCh) < 32'(NUM_CH));
    // a channel finishing this very cycle may be relaunched legally
    startViol = startOk & busyVec[startCh] & ~doneVec[startCh];
    holdCh    = busyVec[excCh] & ~doneVec[excCh];
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      busyN[c] = busyVec[c];
      if (doneVec[c]) busyN[c] = 1'b0;
      if (startOk && startCh == CH_W'(c)) busyN[c] = 1'b1;
    end
  end

  always_comb begin
    stateN           = state;
    cntN             = cnt;
    causeN           = excCause;
    chN              = excCh;
    addrN            = excAddr;
    pcN              = excPc;
    stall            = 1'b0;
    fftNotCompleteEx = 1'b0;
    unique case (state)
      IDLE: begin
        if (guard && !stallMode) begin
          fftNotCompleteEx = 1'b1;
          causeN           = 2'b01;
          chN              = idx;
          addrN            = memAddr;
          pcN              = pc;
          stateN           = EXC;
        end else if (startViol) begin
          fftNotCompleteEx = 1'b1;
          causeN           = 2'b11;
          chN              = startCh;
          addrN            = '0;
          pcN              = pc;
          stateN           = EXC;
        end else if (guard) begin
          stall  = 1'b1;
          cntN   = CNT_W'(1);
          chN    = idx;
          stateN = STALL;
        end
      end
      STALL: begin
        if (startViol) begin
          stall            = 1'b1;
          fftNotCompleteEx = 1'b1;
          causeN           = 2'b11;
          chN              = startCh;
          addrN            = '0;
          pcN              = pc;
          stateN           = EXC;
        end else if (!holdCh) begin
          cntN   = '0;
          stateN = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          stall            = 1'b1;
          fftNotCompleteEx = 1'b1;
          causeN           = 2'b10;
          addrN            = memAddr;
          pcN              = pc;
          stateN           = EXC;
        end else begin
          stall = 1'b1;
          cntN  = cnt + CNT_W'(1);
        end
      end
      EXC: begin
        stall = 1'b1;
        if (excClr) begin
          causeN = 2'b00;
          cntN   = '0;
          stateN = IDLE;
        end
      end
      default: stateN = IDLE;
    endcase
  end

  assign exception = (state == EXC) | fftNotCompleteEx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busyVec  <= '0;
      excCause <= 2'b00;
      excCh    <= '0;
      excAddr  <= '0;
      excPc    <= '0;
    end else begin
      state    <= stateN;
      cnt      <= cntN;
      busyVec  <= busyN;
      excCause <= causeN;
      excCh    <= chN;
      excAddr  <= addrN;
      excPc    <= pcN;
    end
  end

endmodule

// File: tb/tb_fft_access_guard.sv
// Directed self-checking bench for fft_access_guard with the default
// two-channel, 8 KiB-region, 64-cycle-timeout configuration.
module tb_fft_access_guard;

  logic        clk = 1'b0;
  logic        rst;
  logic        startF;
  logic [0:0]  startCh;
  logic [1:0]  doneVec;
  logic        memValid, memWrite;
  logic [31:0] memAddr, pc;
  logic        stallMode, excClr;
  logic [1:0]  busyVec;
  logic        stall, fftNotCompleteEx, exception;
  logic [1:0]  excCause;
  logic [0:0]  excCh;
  logic [31:0] excAddr, excPc;

  int tests = 0;
  int fails = 0;

  fft_access_guard dut (
    .clk(clk), .rst(rst),
    .startF(startF), .startCh(startCh),
    .doneVec(doneVec),
    .memValid(memValid), .memWrite(memWrite),
    .memAddr(memAddr), .pc(pc),
    .stallMode(stallMode), .excClr(excClr),
    .busyVec(busyVec), .stall(stall),
    .fftNotCompleteEx(fftNotCompleteEx),
    .exception(exception), .excCause(excCause),
    .excCh(excCh), .excAddr(excAddr), .excPc(excPc)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    startF = 0; startCh = 0; doneVec = 0;
    memValid = 0; memWrite = 0; memAddr = 0;
    pc = 0; stallMode = 0; excClr = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 0;
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #2;
    tests++;
    if (busyVec !== 2'b00 || stall !== 0 || exception !== 0) begin
      fails++;
      $display("FAIL reset_outs busy=%b stall=%b exc=%b req 00/0/0",
               busyVec, stall, exception);
    end
    cyc();
    tests++;
    if (excCause !== 2'b00 || excAddr !== 0 || excPc !== 0) begin
      fails++;
      $display("FAIL reset_capt cause=%b addr=%h pc=%h req 0",
               excCause, excAddr, excPc);
    end
    rst = 1;
  endtask

  task automatic test_strict();
    apply_reset();
    startF = 1; startCh = 1;
    cyc();
    startF = 0;
    memValid = 1; memWrite = 1;
    memAddr = 32'h2000_2000; pc = 32'h0000_000C;
    @(negedge clk);
    tests++;
    if (fftNotCompleteEx !== 1 || exception !== 1) begin
      fails++;
      $display("FAIL strict_same got fnce=%b exc=%b req 1/1",
               fftNotCompleteEx, exception);
    end
    cyc();
    memValid = 0; memWrite = 0;
    @(negedge clk);
    tests++;
    if (excCause !== 2'b01 || excCh !== 1'b1 ||
        excAddr !== 32'h2000_2000 || excPc !== 32'hC) begin
      fails++;
      $display("FAIL strict_capt cause=%b ch=%0d addr=%h pc=%h",
               excCause, excCh, excAddr, excPc);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (exception !== 1 || stall !== 1) begin
        fails++;
        $display("FAIL strict_hold%0d exc=%b stall=%b req 1/1",
                 i, exception, stall);
      end
      cyc();
    end
    excClr = 1;
    cyc();
    excClr = 0;
    @(negedge clk);
    tests++;
    if (exception !== 0 || excCause !== 2'b00) begin
      fails++;
      $display("FAIL strict_clr exc=%b cause=%b req 0/00",
               exception, excCause);
    end
  endtask

  task automatic test_stall();
    int n;
    apply_reset();
    stallMode = 1;
    startF = 1; startCh = 0;
    cyc();
    startF = 0;
    memValid = 1; memAddr = 32'h2000_0100; pc = 32'h40;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall) n++;
      cyc();
    end
    doneVec = 2'b01;
    @(negedge clk);
    tests++;
    if (stall !== 0 || exception !== 0) begin
      fails++;
      $display("FAIL stall_release stall=%b exc=%b req 0/0",
               stall, exception);
    end
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL stall_count got %0d req 5", n);
    end
    cyc();
    doneVec = 0; memValid = 0;
    @(negedge clk);
    tests++;
    if (busyVec !== 2'b00 || exception !== 0 || stall !== 0) begin
      fails++;
      $display("FAIL stall_after busy=%b exc=%b stall=%b",
               busyVec, exception, stall);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    apply_reset();
    stallMode = 1;
    startF = 1; startCh = 0;
    cyc();
    startF = 0;
    memValid = 1; memAddr = 32'h2000_0000; pc = 32'h80;
    n = 0; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (exception) begin
        seen = 1;
      end else begin
        if (stall) n++;
        if (i == 3) stallMode = 0;
        cyc();
      end
    end
    tests++;
    if (!seen || fftNotCompleteEx !== 1) begin
      fails++;
      $display("FAIL tmo_fire seen=%b fnce=%b req 1/1",
               seen, fftNotCompleteEx);
    end
    tests++;
    if (n !== 64) begin
      fails++;
      $display("FAIL tmo_stalls got %0d req 64", n);
    end
    cyc();
    memValid = 0;
    @(negedge clk);
    tests++;
    if (excCause !== 2'b10 || exception !== 1 || excPc !== 32'h80) begin
      fails++;
      $display("FAIL tmo_cause cause=%b exc=%b pc=%h req 10/1/80",
               excCause, exception, excPc);
    end
  endtask

  task automatic test_edges();
    apply_reset();
    startF = 1; startCh = 0;
    cyc();
    startCh = 1;
    cyc();
    startF = 0;
    memValid = 1; memAddr = 32'h2000_4000;
    @(negedge clk);
    tests++;
    if (fftNotCompleteEx !== 0) begin
      fails++;
      $display("FAIL edge_idx2 fnce=%b req 0", fftNotCompleteEx);
    end
    cyc();
    memAddr = 32'h1FFF_FFFC;
    @(negedge clk);
    tests++;
    if (fftNotCompleteEx !== 0) begin
      fails++;
      $display("FAIL edge_below fnce=%b req 0", fftNotCompleteEx);
    end
    cyc();
    memAddr = 32'h2000_0004; doneVec = 2'b01;
    @(negedge clk);
    tests++;
    if (fftNotCompleteEx !== 0 || exception !== 0) begin
      fails++;
      $display("FAIL edge_done fnce=%b exc=%b req 0/0",
               fftNotCompleteEx, exception);
    end
    cyc();
    memValid = 0; doneVec = 0;
    @(negedge clk);
    tests++;
    if (busyVec !== 2'b10) begin
      fails++;
      $display("FAIL edge_busy got %b req 10", busyVec);
    end
    doneVec = 2'b10;
    cyc();
    startF = 1; startCh = 1; doneVec = 2'b10;
    cyc();
    startF = 0; doneVec = 0;
    @(negedge clk);
    tests++;
    if (busyVec !== 2'b10 || exception !== 0) begin
      fails++;
      $display("FAIL edge_startdone busy=%b exc=%b req 10/0",
               busyVec, exception);
    end
  endtask

  task automatic test_double_start();
    apply_reset();
    startF = 1; startCh = 0;
    cyc();
    pc = 32'h44;
    @(negedge clk);
    tests++;
    if (exception !== 1) begin
      fails++;
      $display("FAIL dbl_same exc=%b req 1", exception);
    end
    cyc();
    startF = 0;
    @(negedge clk);
    tests++;
    if (excCause !== 2'b11 || excCh !== 1'b0 || excAddr !== 0 ||
        excPc !== 32'h44 || busyVec[0] !== 1) begin
      fails++;
      $display("FAIL dbl_capt cause=%b ch=%0d addr=%h pc=%h busy=%b",
               excCause, excCh, excAddr, excPc, busyVec);
    end
    excClr = 1;
    cyc();
    excClr = 0;
    @(negedge clk);
    tests++;
    if (exception !== 0 || excCause !== 2'b00 ||
        busyVec[0] !== 1 || stall !== 0) begin
      fails++;
      $display("FAIL dbl_clr exc=%b cause=%b busy=%b stall=%b",
               exception, excCause, busyVec, stall);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    startF = 1; startCh = 0;
    cyc();
    memValid = 1; memAddr = 32'h2000_0010; pc = 32'h20;
    cyc();
    startF = 0; memValid = 0;
    @(negedge clk);
    tests++;
    if (excCause !== 2'b01 || excAddr !== 32'h2000_0010) begin
      fails++;
      $display("FAIL prio cause=%b addr=%h req 01/20000010",
               excCause, excAddr);
    end
  endtask

  task automatic test_reset_stall();
    apply_reset();
    stallMode = 1;
    startF = 1; startCh = 0;
    cyc();
    startF = 0;
    memValid = 1; memAddr = 32'h2000_0008;
    cyc();
    cyc();
    @(negedge clk);
    tests++;
    if (stall !== 1) begin
      fails++;
      $display("FAIL rst_pre stall=%b req 1", stall);
    end
    rst = 0;
    #1;
    tests++;
    if (stall !== 0 || exception !== 0 || fftNotCompleteEx !== 0 ||
        busyVec !== 2'b00) begin
      fails++;
      $display("FAIL rst_mid stall=%b exc=%b fnce=%b busy=%b",
               stall, exception, fftNotCompleteEx, busyVec);
    end
    memValid = 0;
    cyc();
    rst = 1;
    cyc();
    cyc();
    @(negedge clk);
    tests++;
    if (stall !== 0 || exception !== 0) begin
      fails++;
      $display("FAIL rst_after stall=%b exc=%b req 0/0",
               stall, exception);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    #1;
    test_reset();
    test_strict();
    test_stall();
    test_timeout();
    test_edges();
    test_double_start();
    test_priority();
    test_reset_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
